// File: rtl/instr_loader_pkg.sv
// Shared definitions for the boot loader: FSM encodings and frame constants.
package instr_loader_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned LEN_W          = 16;
    localparam int unsigned LEN_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned STATE_W        = 3;

    localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] S_LEN0 = 3'd1;
    localparam logic [STATE_W-1:0] S_LEN1 = 3'd2;
    localparam logic [STATE_W-1:0] S_DATA = 3'd3;
    localparam logic [STATE_W-1:0] S_CSUM = 3'd4;
    localparam logic [STATE_W-1:0] S_DONE = 3'd5;
    localparam logic [STATE_W-1:0] S_ERR  = 3'd6;

    // States in which the loader consumes stream bytes (and holds the core in reset).
    function automatic logic is_rx_state(input logic [STATE_W-1:0] s);
        return (s == S_LEN0) || (s == S_LEN1) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/instr_loader_byte_packer.sv
// Packs a byte stream into little-endian words; flags the byte that completes a word.
module instr_loader_byte_packer
    import instr_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [BYTE_W-1:0]     byte_in,
    output logic                  word_valid_c,
    output logic [DATA_WIDTH-1:0] word_c
);

    localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] shreg;

    // Newest byte enters at the top, so after four bytes the first one sits in bits[7:0].
    always_comb begin
        word_c       = {byte_in, shreg[DATA_WIDTH-1:BYTE_W]};
        word_valid_c = byte_valid && (cnt == CNT_W'(BYTES_PER_WORD - 1));
    end

    // Byte position counter and shift register; clear drops any partial word.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (byte_valid) begin
            cnt   <= cnt + CNT_W'(1);
            shreg <= word_c;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Boot loader: receives a length-prefixed byte frame, writes words to instruction
// memory from address 0 and verifies the trailing XOR checksum.
module instr_loader #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned MEM_SIZE      = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic                     mem_wr_en,
    output logic [ADDRESS_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0]    mem_wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    import instr_loader_pkg::*;

    localparam int unsigned IDX_W = $clog2(MEM_SIZE) + 1;

    logic [STATE_W-1:0]    state;
    logic [STATE_W-1:0]    next_state;
    logic [BYTE_W-1:0]     len_lo;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      len_n;
    logic [IDX_W-1:0]      word_idx;
    logic [BYTE_W-1:0]     csum;
    logic                  acc;
    logic                  start_acc;
    logic                  last_word;
    logic                  word_valid_c;
    logic [DATA_WIDTH-1:0] word_c;

    // Handshake and frame-position decodes.
    always_comb begin
        acc       = rx_valid && rx_ready;
        start_acc = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
        len_n     = {rx_data, len_lo};
        last_word = ((LEN_W'(word_idx) + LEN_W'(1)) == len_q);
    end

    instr_loader_byte_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear        (start_acc),
        .byte_valid   (acc && (state == S_DATA)),
        .byte_in      (rx_data),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) next_state = S_LEN0;
            end
            S_LEN0: begin
                if (acc) next_state = S_LEN1;
            end
            S_LEN1: begin
                if (acc) begin
                    if (len_n > LEN_W'(MEM_SIZE))  next_state = S_ERR;
                    else if (len_n == '0)          next_state = S_CSUM;
                    else                           next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (word_valid_c && last_word) next_state = S_CSUM;
            end
            S_CSUM: begin
                if (acc) next_state = ((csum ^ rx_data) == '0) ? S_DONE : S_ERR;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Status flags follow the next state; length, checksum, word index and memory write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            len_lo      <= '0;
            len_q       <= '0;
            word_idx    <= '0;
            csum        <= '0;
        end else begin
            rx_ready  <= is_rx_state(next_state);
            busy      <= is_rx_state(next_state);
            done      <= (next_state == S_DONE);
            error     <= (next_state == S_ERR);
            mem_wr_en <= 1'b0;
            if (start_acc) begin
                len_lo   <= '0;
                len_q    <= '0;
                word_idx <= '0;
                csum     <= '0;
            end else if (acc) begin
                csum <= csum ^ rx_data;
                if (state == S_LEN0) len_lo <= rx_data;
                if (state == S_LEN1) len_q  <= len_n;
                if (word_valid_c) begin
                    mem_wr_en   <= 1'b1;
                    mem_wr_addr <= ADDRESS_WIDTH'({word_idx, 2'b00});
                    mem_wr_data <= word_c;
                    word_idx    <= word_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader.
module tb_instr_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        busy;
    logic        done;
    logic        error;

    int n_cmp;
    int n_err;

    logic [31:0] wa [$];
    logic [31:0] wd [$];

    logic [7:0] fr   [0:10];
    int         gaps [0:10];

    instr_loader #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .MEM_SIZE      (512)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every memory write, one entry per cycle mem_wr_en is high.
    always @(negedge clk) begin
        if (!rst && mem_wr_en) begin
            wa.push_back(mem_wr_addr);
            wd.push_back(mem_wr_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one byte at a negedge and hold it until the loader accepts it (bounded).
    task automatic send_byte(input logic [7:0] b);
        logic ok;
        logic rdy;
        ok       = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            rdy = rx_ready;
            @(negedge clk);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        rx_valid = 1'b0;
        chk("byte_accept", 32'(ok), 32'd1);
    endtask

    task automatic send_fr(input int n, input logic use_gaps);
        for (int i = 0; i < n; i++) begin
            if (use_gaps) repeat (gaps[i]) @(negedge clk);
            send_byte(fr[i]);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_case1_writes(input string tag);
        @(negedge clk);
        chk({tag, "_wr_count"}, 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            chk({tag, "_addr0"}, wa[0], 32'h0000_0000);
            chk({tag, "_data0"}, wd[0], 32'hDEAD_BEEF);
            chk({tag, "_addr1"}, wa[1], 32'h0000_0004);
            chk({tag, "_data1"}, wd[1], 32'h0000_0013);
        end
    endtask

    task automatic check_flags(input string tag, input logic e_done, input logic e_err,
                               input logic e_busy, input logic e_rdy);
        chk({tag, "_done"},     32'(done),     32'(e_done));
        chk({tag, "_error"},    32'(error),    32'(e_err));
        chk({tag, "_busy"},     32'(busy),     32'(e_busy));
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'(e_rdy));
    endtask

    task automatic load_case1();
        fr = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h13, 8'h00, 8'h00, 8'h00, 8'h33};
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        gaps     = '{1, 3, 0, 2, 1, 0, 3, 2, 0, 1, 2};

        // Reset state
        repeat (3) @(negedge clk);
        check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_wr_en", 32'(mem_wr_en), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_flags("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Case 1: two-word frame, good checksum
        load_case1();
        wa.delete(); wd.delete();
        pulse_start();
        chk("c1_busy_after_start", 32'(busy), 32'd1);
        chk("c1_ready_after_start", 32'(rx_ready), 32'd1);
        send_fr(11, 1'b0);
        check_flags("c1_end", 1'b1, 1'b0, 1'b0, 1'b0);
        check_case1_writes("c1");

        // Case 2: same frame, bad checksum
        fr[10] = 8'h34;
        wa.delete(); wd.delete();
        pulse_start();
        chk("c2_done_cleared", 32'(done), 32'd0);
        send_fr(11, 1'b0);
        check_flags("c2_end", 1'b0, 1'b1, 1'b0, 1'b0);
        check_case1_writes("c2");

        // Case 3: N=513 exceeds memory depth
        wa.delete(); wd.delete();
        pulse_start();
        chk("c3_error_cleared", 32'(error), 32'd0);
        send_byte(8'h01);
        send_byte(8'h02);
        check_flags("c3_end", 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("c3_wr_count", 32'(wa.size()), 32'd0);

        // Case 4: good frame with idle gaps between bytes
        load_case1();
        wa.delete(); wd.delete();
        pulse_start();
        send_fr(11, 1'b1);
        check_flags("c4_end", 1'b1, 1'b0, 1'b0, 1'b0);
        check_case1_writes("c4");

        // Case 5: reset after two data bytes, then a full reload
        wa.delete(); wd.delete();
        pulse_start();
        send_fr(4, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_flags("c5_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("c5_rst_wr_en",   32'(mem_wr_en), 32'd0);
        chk("c5_rst_wr_addr", mem_wr_addr,    32'd0);
        chk("c5_rst_wr_data", mem_wr_data,    32'd0);
        rst = 1'b0;
        @(negedge clk);
        wa.delete(); wd.delete();
        pulse_start();
        send_fr(11, 1'b0);
        check_flags("c5_end", 1'b1, 1'b0, 1'b0, 1'b0);
        check_case1_writes("c5");

        // Case 6: empty image, start pulsed while busy
        wa.delete(); wd.delete();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        pulse_start();
        chk("c6_busy_mid", 32'(busy), 32'd1);
        chk("c6_ready_mid", 32'(rx_ready), 32'd1);
        send_byte(8'h00);
        check_flags("c6_end", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("c6_wr_count", 32'(wa.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
